// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmitter: flit field sizes and FSM state encoding.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds the PAR state and one even-parity bit).
package serial_tx_pkg;

  localparam int unsigned HdrSz  = 8;
  localparam int unsigned PlSz   = 8;
  localparam int unsigned AddrSz = 4;
  localparam int unsigned FlitSz = HdrSz + PlSz + AddrSz;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWaitCh = 3'd1,
    StData   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    StPar    = 3'd3,
`endif
    StGap    = 3'd4
  } tx_state_e;

  // Even parity over a whole flit.
  function automatic logic even_parity(logic [FlitSz-1:0] flit);
    return ^flit;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Producer/channel-facing signal bundle of the serial transmitter.
// master: environment side (producer + downstream status); slave: the transmitter.
interface serial_tx_if;
  import serial_tx_pkg::*;

  logic [FlitSz-1:0] parallel_in;
  logic              req;
  logic              busy;
  logic              channel_busy;
  logic              serial_out;

  modport master (
    output parallel_in,
    output req,
    output channel_busy,
    input  busy,
    input  serial_out
  );

  modport slave (
    input  parallel_in,
    input  req,
    input  channel_busy,
    output busy,
    output serial_out
  );

endinterface

// File: rtl/serial_tx_shreg.sv
// W-bit load / shift-right register with a bit counter; done_o flags that the bit
// currently in position 0 is the last one of the frame.
module serial_tx_shreg #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         shift_i,
  output logic         bit_o,
  output logic         done_o
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic [W-1:0]    shreg_d, shreg_q;
  logic [CntW-1:0] cnt_d, cnt_q;

  // Load restarts the count; each shift consumes the LSB.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Register and counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_o  = shreg_q[0];
  assign done_o = (cnt_q == CntW'(W - 1));

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial flit transmitter: start bit, W data bits LSB first, optional
// even-parity bit, then gap_cycles idle-low cycles before the next flit is accepted.
// Optional feature macro: SERIAL_TX_PARITY_EN.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int          id         = -1,
  parameter int unsigned gap_cycles = 1
) (
  input logic       clk,
  input logic       reset,
  serial_tx_if.slave bus
);

  localparam logic [3:0] GapLast = 4'(gap_cycles - 1);

  tx_state_e  state_d, state_q;
  logic       busy_d, busy_q;
  logic       serial_out_d, serial_out_q;
  logic [3:0] gap_cnt_d, gap_cnt_q;
  logic       load, shift;
  logic       sh_bit, sh_done;
  logic       accept;
`ifdef SERIAL_TX_PARITY_EN
  logic       parity_d, parity_q;
`endif

  // busy is only low in IDLE, so this is the handover condition.
  assign accept = (state_q == StIdle) && !busy_q && bus.req;

  serial_tx_shreg #(
    .W(FlitSz)
  ) u_shreg (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .data_i (bus.parallel_in),
    .shift_i(shift),
    .bit_o  (sh_bit),
    .done_o (sh_done)
  );

  // Next-state, handshake and serial line logic.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    serial_out_d = serial_out_q;
    gap_cnt_d    = gap_cnt_q;
    load         = 1'b0;
    shift        = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      StIdle: begin
        if (busy_q) begin
          // First edge after reset release opens the handshake.
          busy_d = 1'b0;
        end else if (bus.req) begin
          load   = 1'b1;
          busy_d = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = even_parity(bus.parallel_in);
`endif
          if (!bus.channel_busy) begin
            serial_out_d = 1'b1;
            state_d      = StData;
          end else begin
            state_d = StWaitCh;
          end
        end
      end
      StWaitCh: begin
        if (!bus.channel_busy) begin
          serial_out_d = 1'b1;
          state_d      = StData;
        end
      end
      StData: begin
        serial_out_d = sh_bit;
        shift        = 1'b1;
        if (sh_done) begin
          gap_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
          state_d = StPar;
`else
          state_d = StGap;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      StPar: begin
        serial_out_d = parity_q;
        gap_cnt_d    = '0;
        state_d      = StGap;
      end
`endif
      StGap: begin
        serial_out_d = 1'b0;
        if (gap_cnt_q == GapLast) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        serial_out_d = 1'b0;
        state_d      = StIdle;
      end
    endcase
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      busy_q       <= 1'b1;
      serial_out_q <= 1'b0;
      gap_cnt_q    <= '0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      serial_out_q <= serial_out_d;
      gap_cnt_q    <= gap_cnt_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.serial_out = serial_out_q;

`ifndef SYNTHESIS
  // Per-flit trace line for instances given an id.
  always @(posedge clk) begin
    if (!reset && accept && (id != -1)) begin
      $display("##,tx,%0d,%0h", id, bus.parallel_in[FlitSz-1 -: HdrSz]);
    end
  end
`endif

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-to-serial transmitter for one flit per frame.
- Sits directly upstream of the serial receiver that feeds sink blocks.
- Producer side (router output or traffic source) hands over a full flit via a req/busy handshake.
- Flit is shifted onto a 1-bit serial channel; start only when the downstream receiver reports channel_busy low.

Parameters:
- id, -1, instance id; when not -1 the block prints a $display trace line per transmitted flit.
- gap_cycles, 1, idle-low cycles forced on serial_out after each frame (min 1, max 15).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- parallel_in  input  `HDR_SZ+`PL_SZ+`ADDR_SZ (W)  flit; header in MSBs, address in LSBs.
- req  input  1  producer has a valid flit on parallel_in.
- busy  output  1  registered; producer may hand over only while low.
- channel_busy  input  1  downstream receiver cannot accept a new frame.
- serial_out  output  1  serial line; idle level 0.

Behaviour:
- Reset (async, high): state=IDLE, busy=1, serial_out=0, shift reg=0, bit counter=0. A reset mid-frame aborts the frame.
- First clk edge after reset release: busy<=0.
- Accept: at an edge with req=1 and busy=0, latch parallel_in into the shift reg and set busy<=1. req with busy=1 is ignored; the producer holds the data.
- FSM states: IDLE, WAIT_CH, DATA, PAR (only with the optional feature), GAP.
- IDLE, accept, channel_busy=0: serial_out<=1 (start bit), counter<=0, go to DATA.
- IDLE, accept, channel_busy=1: go to WAIT_CH; serial_out stays 0.
- WAIT_CH: when channel_busy=0 at an edge, serial_out<=1 (start bit) and go to DATA; otherwise stay, with no timeout.
- DATA: each edge drives serial_out<=shreg[0], shifts right and increments the counter. After W bits go to PAR if enabled, else to GAP.
- GAP: serial_out<=0 for gap_cycles edges, then IDLE with busy<=0.
- channel_busy is sampled only in IDLE and WAIT_CH; changes during DATA/PAR/GAP are ignored.
- Timing, accept at edge N with channel free:
  - start bit visible in cycle N+1;
  - data bit i in cycle N+2+i;
  - last data bit in cycle N+1+W;
  - busy low again after N+1+W+gap_cycles (+1 with parity).
- Counter width is $clog2(W+1); W ≤ 255 is required.
- Trace: at the accept edge, if id != -1, print "##,tx,<id>,<header field>".

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: PAR state after the last data bit drives one even-parity bit (XOR of all W bits). The frame is 1+W+1 bits and every timing after the data bits shifts by one cycle.
- Undefined: there is no PAR state and the frame is 1+W bits.
- The receiver must be built with the same macro setting.

Decomposition:
- Shared defines header: HDR_SZ, PL_SZ, ADDR_SZ, derived FLIT_SZ (= sum), and FSM state encodings.
- One natural sub-module: serial_tx_shreg, a W-bit load/shift-right register with bit counter and done flag. The parent keeps the FSM, handshake and parity.

Test Plan (bench HDR_SZ=8, PL_SZ=8, ADDR_SZ=4, W=20, gap_cycles=1):
- Reset then idle: busy=1 during reset, 0 one cycle after release; serial_out=0 throughout.
- Single frame, channel free: req with 20'hA5C31 → serial_out shows 1 then bits 1,0,0,0,1,1,0,0,... LSB first; busy low again 22 cycles after accept.
- Channel blocked: channel_busy=1 for 7 cycles at accept → serial_out stays 0 and busy=1; start bit appears one cycle after channel_busy falls.
- Back-to-back: req held high with 20'h00001 then 20'hFFFFF → exactly one 0 gap cycle between frames; no flit lost or duplicated.
- Reset mid-frame: assert reset at data bit 10 → serial_out=0 and busy=1 immediately; next frame after release is transmitted intact.
- Parity (SERIAL_TX_PARITY_EN): 20'h00007 → parity bit 1; 20'h00003 → parity bit 0; busy low 23 cycles after accept.
